// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined MIPS core.
// Drives the instruction-memory address from the PC register, captures the
// fetched word into the IF/ID register, and selects the next PC from the
// ID-stage Jump/Branch decode. Control resolves in ID with no delay slot, so
// every taken redirect squashes the single wrong-path word already fetched.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   stall             ID hazard stall: hold PC and IF/ID
//   imem_addr         byte address to instruction memory (= pc)
//   imem_rdata        combinational instruction word at imem_addr
//   id_valid          ID-stage instruction is real (tied to ifid_valid)
//   id_jump           00 none, 01 jr, 10 j, 11 jal
//   id_branch_taken   branch condition true in ID
//   id_pc_plus4       PC+4 of the ID-stage instruction
//   id_jump_index     instr[25:0] of the ID-stage instruction
//   id_branch_offset  sign-extended imm16
//   id_jr_target      forwarded rs value for jr
//   ifid_instr        registered instruction to the decoder
//   ifid_pc_plus4     registered PC+4 of ifid_instr
//   ifid_valid        ifid_instr is a real fetched instruction
//   misaligned        pulse when a taken jr target has bits[1:0] != 0
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        id_valid,
  input  logic [1:0]  id_jump,
  input  logic        id_branch_taken,
  input  logic [31:0] id_pc_plus4,
  input  logic [25:0] id_jump_index,
  input  logic [31:0] id_branch_offset,
  input  logic [31:0] id_jr_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        misaligned
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_pc;

  assign seq_pc   = pc_q + 32'd4;
  assign redirect = id_valid & ((id_jump != 2'b00) | id_branch_taken);

  // Jumps take priority over a simultaneously taken branch.
  always_comb begin
    target = id_pc_plus4 + {id_branch_offset[29:0], 2'b00};
    if (id_jump == 2'b01)
      target = {id_jr_target[31:2], 2'b00};
    else if (id_jump[1])
      target = {id_pc_plus4[31:28], id_jump_index, 2'b00};
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    // Stall ignores redirect: ID re-presents it once the stall drops.
    if (!stall) begin
      if (redirect) begin
        pc_d    = target;
        instr_d = NOP_WORD;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
      end else begin
        pc_d    = seq_pc;
        instr_d = imem_rdata;
        pcp4_d  = seq_pc;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  // Only flag a misaligned jr that actually redirects this cycle.
  assign misaligned = redirect & ~stall & ~reset & (id_jump == 2'b01) &
                      (|id_jr_target[1:0]);

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pcp4_q;
  assign ifid_valid    = valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. It drives the instruction-memory address and captures fetched words into the IF/ID register that feeds the control decoder. It also consumes the decoder's Jump/Branch encoding from the ID stage to select the next PC. Control resolves in ID with no branch delay slot: every taken redirect squashes the one wrong-path word already fetched.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on squash or reset (sll $0,$0,0).

Ports (clock is `clk`; reset is `reset`, synchronous and active-high, one clock):
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from the ID stage; holds PC and IF/ID.
- imem_addr  out  32  byte address to instruction memory; equals the `pc` register.
- imem_rdata  in  32  instruction word at imem_addr; combinational read, valid the same cycle.
- id_valid  in  1  the ID-stage instruction is real, not a bubble; externally tied to ifid_valid.
- id_jump  in  2  decoder Jump: 00 none, 01 jr, 10 j, 11 jal.
- id_branch_taken  in  1  branch condition evaluated true in ID.
- id_pc_plus4  in  32  PC+4 of the ID-stage instruction.
- id_jump_index  in  26  instr[25:0] of the ID-stage instruction.
- id_branch_offset  in  32  sign-extended imm16 of the ID-stage instruction.
- id_jr_target  in  32  forwarded rs value, used for jr.
- ifid_instr  out  32  registered instruction to the decoder.
- ifid_pc_plus4  out  32  registered PC+4 of ifid_instr.
- ifid_valid  out  1  ifid_instr is a real fetched instruction.
- misaligned  out  1  one-cycle pulse when a jr target has bits[1:0] != 0.

## Operation
Next-PC selection. `redirect` = id_valid & (id_jump != 00 | id_branch_taken). The first matching rule applies:
1. **id_jump = 01 (jr):** next PC = {id_jr_target[31:2], 2'b00}. If id_jr_target[1:0] != 0, `misaligned` = 1 for that cycle.
2. **id_jump = 10 or 11 (j, jal):** next PC = {id_pc_plus4[31:28], id_jump_index, 2'b00}.
3. **id_branch_taken:** next PC = id_pc_plus4 + (id_branch_offset << 2).
4. **Otherwise:** next PC = pc + 4.

Arithmetic and priority rules:
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. A negative offset wraps the same way.
- A jump overrides id_branch_taken if both are asserted.
- Writing $31 for jal is not done here. ID already holds PC+4 in id_pc_plus4.

Register update at each rising edge, highest priority first:
- **reset:** pc <= RESET_PC; ifid_instr <= NOP_WORD; ifid_pc_plus4 <= 0; ifid_valid <= 0.
- **stall:** pc and all IF/ID outputs hold. Redirect inputs are ignored because ID re-presents them once the stall drops.
- **redirect:** pc <= target; ifid_instr <= NOP_WORD; ifid_valid <= 0 (squash); ifid_pc_plus4 <= 0.
- **otherwise:** pc <= pc + 4; ifid_instr <= imem_rdata; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1.

Other behaviour:
- `misaligned` is combinational from the current inputs, and is gated by redirect & ~stall & ~reset.
- Reset asserted mid-stall or mid-redirect wins unconditionally. The next non-reset cycle fetches RESET_PC.

## Timing
- **Reset values:** pc = RESET_PC, imem_addr = RESET_PC, ifid_instr = NOP_WORD, ifid_pc_plus4 = 0, ifid_valid = 0, misaligned = 0.
- **Fetch latency:** the word at address A reaches ifid_instr one edge after imem_addr = A.
- **Sequential throughput:** one instruction per cycle.
- **Redirect penalty:** exactly one bubble.
  - Redirect seen in cycle N: imem_addr = target in cycle N+1.
  - The target word appears in ifid_instr in cycle N+2.
  - ifid_valid = 0 during cycle N+1.
- **Stall of k cycles:** outputs are frozen for k cycles. No word is dropped or duplicated.
- **Redirect loop:** redirect cannot fire on consecutive cycles without a stall, because the squashed slot presents id_valid = 0.

## Test plan
- **Reset and sequential fetch:** imem holds words W0..W3 at 0x0..0xC; release reset. Required: ifid_instr = W0, W1, W2, W3 on successive cycles; ifid_pc_plus4 = 4, 8, 12, 16; ifid_valid = 1 from the 2nd post-reset edge.
- **Jump to index:** j with id_jump_index = 26'h0000040 and id_pc_plus4 = 0x0000_0010. Required: imem_addr = 0x0000_0100 next cycle; one squash cycle (ifid_instr = 0, ifid_valid = 0); then the word at 0x100.
- **Backward branch with wrap:** id_branch_taken with id_pc_plus4 = 0x0000_0004 and offset = 32'hFFFF_FFFE. Required: imem_addr = 0xFFFF_FFFC. The following sequential fetch is at 0x0000_0000.
- **jr with priority and misalignment:** id_jump = 01, id_jr_target = 0x0000_0203, id_branch_taken = 1. Required: imem_addr = 0x0000_0200 and a one-cycle misaligned pulse; the branch target is not taken.
- **Stall against redirect:** stall = 1 for 3 cycles while a j redirect is presented, then stall drops with the redirect still presented. Required: pc and IF/ID hold for 3 cycles, and the redirect takes effect on the first unstalled edge. With id_valid = 0, the same inputs cause no redirect.
- **Mid-operation reset:** assert reset in the same cycle as a redirect. Required: pc = RESET_PC, ifid_valid = 0, misaligned = 0.
